// File: rtl/mips_decode_stage_if.sv
// Decode-stage handshake bundle: fetch side (in_*/instr/flush) and EX side (out_*/control).
// master = the decode stage itself, slave = the surrounding fetch/EX logic (or a bench).
// Ports: in_valid/in_ready/instr/flush from fetch+EX, out_valid/out_ready plus registered control to EX.
interface mips_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_q;
  logic        memtoreg;
  logic        memwrite;
  logic        alusrcbimm;
  logic        regwrite;
  logic        dojump;
  logic        isbranch;
  logic        branchne;
  logic [4:0]  destreg;
  logic [2:0]  alucontrol;
  logic        immhi;
  logic        immzext;
  logic        illegal;

  modport master (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, instr_q, memtoreg, memwrite, alusrcbimm, regwrite,
           dojump, isbranch, branchne, destreg, alucontrol, immhi, immzext, illegal
  );

  modport slave (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, instr_q, memtoreg, memwrite, alusrcbimm, regwrite,
           dojump, isbranch, branchne, destreg, alucontrol, immhi, immzext, illegal
  );
endinterface

// File: rtl/mips_decode_stage.sv
// MIPS decode stage: decodes one instruction per cycle into a registered control bundle.
// Latency 1 cycle; load-use inserts one bubble, mflo/mfhi/mult wait on the multiply-busy counter.
// Backpressure: in_ready drops on !out_ready with a held bundle, on flush, reset and either stall.
// Ports: clk, reset (async, active-high), bus (mips_decode_stage_if.master).
// Optional: define DECODE_EXT_EN to decode lui/ori; otherwise they are illegal and immhi/immzext stay 0.
module mips_decode_stage #(
  parameter int MULT_LATENCY = 4,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_decode_stage_if.master  bus
);

  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic       alusrcbimm;
    logic       regwrite;
    logic       dojump;
    logic       isbranch;
    logic       branchne;
    logic [4:0] destreg;
    logic [2:0] alucontrol;
    logic       immhi;
    logic       immzext;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{alucontrol: 3'b101, default: '0};
  localparam logic [CNT_W-1:0] MUL_LAT = CNT_W'(MULT_LATENCY);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD  = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101011;
  localparam logic [5:0] FN_MULT = 6'b011001;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  ctrl_t      dec;
  ctrl_t      ctrl_q;
  logic       out_valid_q;
  logic [31:0] instr_q;
  logic [CNT_W-1:0] busy_cnt;
  logic       uses_rt, is_mulop, held_mult;
  logic       lu_stall, mul_stall, in_ready_c;
  logic       accept, consume;

  assign op    = bus.instr[31:26];
  assign rs    = bus.instr[25:21];
  assign rt    = bus.instr[20:16];
  assign rd    = bus.instr[15:11];
  assign funct = bus.instr[5:0];

  // Combinational decode of the incoming word; every path starts from the safe idle bundle.
  always_comb begin
    dec = CTRL_IDLE;
    case (op)
      OP_RTYPE: begin
        dec.destreg  = rd;
        dec.regwrite = 1'b1;
        case (funct)
          FN_ADD:  dec.alucontrol = 3'b101;
          FN_SUB:  dec.alucontrol = 3'b001;
          FN_AND:  dec.alucontrol = 3'b111;
          FN_OR:   dec.alucontrol = 3'b110;
          FN_SLT:  dec.alucontrol = 3'b000;
          FN_MULT: begin
            dec.alucontrol = 3'b100;
            dec.regwrite   = 1'b0;  // HI/LO are written inside the multiplier
          end
          FN_MFHI: dec.alucontrol = 3'b011;
          FN_MFLO: dec.alucontrol = 3'b010;
          default: begin
            dec = CTRL_IDLE;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        dec.destreg    = rt;
        dec.memtoreg   = 1'b1;
        dec.regwrite   = 1'b1;
        dec.alusrcbimm = 1'b1;
      end
      OP_SW: begin
        dec.destreg    = rt;
        dec.memwrite   = 1'b1;
        dec.alusrcbimm = 1'b1;
      end
      OP_BEQ: begin
        dec.destreg    = rt;
        dec.isbranch   = 1'b1;
        dec.alucontrol = 3'b001;
      end
      OP_BNE: begin
        dec.destreg    = rt;
        dec.isbranch   = 1'b1;
        dec.branchne   = 1'b1;
        dec.alucontrol = 3'b001;
      end
      OP_ADDIU: begin
        dec.destreg    = rt;
        dec.regwrite   = 1'b1;
        dec.alusrcbimm = 1'b1;
      end
      OP_J: dec.dojump = 1'b1;
`ifdef DECODE_EXT_EN
      OP_LUI: begin
        dec.destreg    = rt;
        dec.regwrite   = 1'b1;
        dec.alusrcbimm = 1'b1;
        dec.immhi      = 1'b1;
      end
      OP_ORI: begin
        dec.destreg    = rt;
        dec.regwrite   = 1'b1;
        dec.alusrcbimm = 1'b1;
        dec.alucontrol = 3'b110;
        dec.immzext    = 1'b1;
      end
`else
      OP_LUI, OP_ORI: dec.illegal = 1'b1;
`endif
      default: dec.illegal = 1'b1;
    endcase
  end

  assign uses_rt  = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  assign is_mulop = (op == OP_RTYPE) &&
                    ((funct == FN_MULT) || (funct == FN_MFLO) || (funct == FN_MFHI));
  // Only a mult bundle carries alucontrol 100.
  assign held_mult = out_valid_q && (ctrl_q.alucontrol == 3'b100);

  assign consume = out_valid_q && bus.out_ready && !bus.flush;

  // Held lw being consumed now while the incoming word reads its destination: one bubble.
  assign lu_stall = out_valid_q && bus.out_ready && ctrl_q.memtoreg &&
                    (ctrl_q.destreg != 5'd0) &&
                    ((rs == ctrl_q.destreg) || (uses_rt && (rt == ctrl_q.destreg)));

  // A mult still sitting in the output register has not loaded the counter yet, so it
  // blocks mul ops too; otherwise an mflo right behind it would slip past the interlock.
  assign mul_stall = is_mulop && ((busy_cnt != '0) || held_mult);

  assign in_ready_c = !reset && (!out_valid_q || bus.out_ready) && !bus.flush &&
                      !lu_stall && !mul_stall;
  assign accept     = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      ctrl_q      <= CTRL_IDLE;
      busy_cnt    <= '0;
    end else begin
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        instr_q     <= bus.instr;
        ctrl_q      <= dec;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end

      if (consume && held_mult) begin
        busy_cnt <= MUL_LAT;
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.instr_q    = instr_q;
  assign bus.memtoreg   = ctrl_q.memtoreg;
  assign bus.memwrite   = ctrl_q.memwrite;
  assign bus.alusrcbimm = ctrl_q.alusrcbimm;
  assign bus.regwrite   = ctrl_q.regwrite;
  assign bus.dojump     = ctrl_q.dojump;
  assign bus.isbranch   = ctrl_q.isbranch;
  assign bus.branchne   = ctrl_q.branchne;
  assign bus.destreg    = ctrl_q.destreg;
  assign bus.alucontrol = ctrl_q.alucontrol;
`ifdef DECODE_EXT_EN
  assign bus.immhi      = ctrl_q.immhi;
  assign bus.immzext    = ctrl_q.immzext;
`else
  assign bus.immhi      = 1'b0;
  assign bus.immzext    = 1'b0;
`endif
  assign bus.illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Bench for mips_decode_stage: directed vectors, scoreboard queue, negedge monitor.
// Stimulus drives at posedge+1, monitor samples at negedge.
// Expected bundles are hand-written per vector.
module tb_mips_decode_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [6:0]  f;    // {memtoreg,memwrite,alusrcbimm,regwrite,dojump,isbranch,branchne}
    logic [4:0]  destreg;
    logic [2:0]  alucontrol;
    logic [2:0]  x;    // {immhi,immzext,illegal}
  } bund_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   fails = 0;
  bund_t exp_q[$];

  mips_decode_stage_if dif();

  mips_decode_stage #(.MULT_LATENCY(4), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dif)
  );

  always #5 clk = ~clk;

  function automatic bund_t mk(input logic [31:0] i, input logic [6:0] f,
                               input logic [4:0] d, input logic [2:0] a, input logic [2:0] x);
    bund_t b;
    b.instr = i; b.f = f; b.destreg = d; b.alucontrol = a; b.x = x;
    return b;
  endfunction

  function automatic bund_t got();
    bund_t b;
    b.instr      = dif.instr_q;
    b.f          = {dif.memtoreg, dif.memwrite, dif.alusrcbimm, dif.regwrite,
                    dif.dojump, dif.isbranch, dif.branchne};
    b.destreg    = dif.destreg;
    b.alucontrol = dif.alucontrol;
    b.x          = {dif.immhi, dif.immzext, dif.illegal};
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: a bundle is consumed whenever it is valid, EX is ready and no flush kills it.
  always @(negedge clk) begin
    if (!reset && dif.out_valid && dif.out_ready && !dif.flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bundle", 64'(got()), 64'(0));
      end else begin
        bund_t e;
        e = exp_q.pop_front();
        chk("bundle", 64'(got()), 64'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction until accepted; reports stall cycles and out_valid in the accept cycle.
  task automatic send(input logic [31:0] i, input bund_t e, input bit push,
                      output int stalls, output logic ov_acc);
    int n;
    bit ok;
    n = 0; ok = 0; ov_acc = 1'b0;
    dif.in_valid = 1'b1;
    dif.instr    = i;
    while (!ok && n <= 40) begin
      @(negedge clk);
      if (dif.in_ready) begin
        ok = 1;
        ov_acc = dif.out_valid;
      end else begin
        n++;
      end
    end
    if (!ok) chk("accept_timeout", 64'(n), 64'(0));
    if (ok && push) exp_q.push_back(e);
    tick();
    dif.in_valid = 1'b0;
    stalls = n;
  endtask

  task automatic s(input logic [31:0] i, input bund_t e);
    int st;
    logic ov;
    send(i, e, 1'b1, st, ov);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Hold a bundle with out_ready=0, then flush with out_ready raised in the same cycle.
  task automatic flush_held(input logic [31:0] i, input bund_t e);
    int st;
    logic ov;
    dif.out_ready = 1'b0;
    send(i, e, 1'b0, st, ov);
    @(negedge clk);
    chk("held_valid", 64'(dif.out_valid), 64'(1));
    tick();
    dif.flush = 1'b1;
    dif.out_ready = 1'b1;
    dif.in_valid = 1'b1;
    dif.instr = 32'h24020005;
    @(negedge clk);
    chk("flush_in_ready", 64'(dif.in_ready), 64'(0));
    tick();
    dif.flush = 1'b0;
    dif.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(dif.out_valid), 64'(0));
    tick();
  endtask

  localparam logic [2:0] ILL = 3'b001;

  initial begin
    int st;
    logic ov;
    bund_t b_mult, b_mflo;
    dif.in_valid = 1'b0;
    dif.instr = '0;
    dif.flush = 1'b0;
    dif.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(dif.in_ready), 64'(0));
    chk("rst_bundle", 64'(got()), 64'(mk(32'h0, 7'b0, 5'd0, 3'b101, 3'b000)));
    chk("rst_out_valid", 64'(dif.out_valid), 64'(0));
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(dif.in_ready), 64'(1));
    tick();

    // addiu $2,$0,5: one-cycle latency
    dif.in_valid = 1'b1;
    dif.instr = 32'h24020005;
    @(negedge clk);
    exp_q.push_back(mk(32'h24020005, 7'b0011000, 5'd2, 3'b101, 3'b000));
    tick();
    dif.in_valid = 1'b0;
    @(negedge clk);
    chk("addiu_latency_valid", 64'(dif.out_valid), 64'(1));
    idle(2);

    // Decode table sweep
    s(32'hAC030004, mk(32'hAC030004, 7'b0110000, 5'd3, 3'b101, 3'b000)); // sw
    s(32'h10220004, mk(32'h10220004, 7'b0000010, 5'd2, 3'b001, 3'b000)); // beq
    s(32'h14220004, mk(32'h14220004, 7'b0000011, 5'd2, 3'b001, 3'b000)); // bne
    s(32'h08000010, mk(32'h08000010, 7'b0000100, 5'd0, 3'b101, 3'b000)); // j
    s(32'h00A62023, mk(32'h00A62023, 7'b0001000, 5'd4, 3'b001, 3'b000)); // sub
    s(32'h00A62024, mk(32'h00A62024, 7'b0001000, 5'd4, 3'b111, 3'b000)); // and
    s(32'h00A62025, mk(32'h00A62025, 7'b0001000, 5'd4, 3'b110, 3'b000)); // or
    s(32'h00A6202B, mk(32'h00A6202B, 7'b0001000, 5'd4, 3'b000, 3'b000)); // slt
    s(32'hFC000000, mk(32'hFC000000, 7'b0000000, 5'd0, 3'b101, ILL));    // opcode 0x3F
    s(32'h0000003F, mk(32'h0000003F, 7'b0000000, 5'd0, 3'b101, ILL));    // funct 0x3F
`ifdef DECODE_EXT_EN
    s(32'h3C011234, mk(32'h3C011234, 7'b0011000, 5'd1, 3'b101, 3'b100)); // lui
    s(32'h342200FF, mk(32'h342200FF, 7'b0011000, 5'd2, 3'b110, 3'b010)); // ori
`else
    s(32'h3C011234, mk(32'h3C011234, 7'b0000000, 5'd0, 3'b101, ILL));    // lui
    s(32'h342200FF, mk(32'h342200FF, 7'b0000000, 5'd0, 3'b101, ILL));    // ori
`endif
    idle(2);

    // Load-use: lw $3 then add $4,$3,$3 -> one stall, bubble in the accept cycle
    s(32'h8C030000, mk(32'h8C030000, 7'b1011000, 5'd3, 3'b101, 3'b000));
    send(32'h00632021, mk(32'h00632021, 7'b0001000, 5'd4, 3'b101, 3'b000), 1'b1, st, ov);
    chk("lu_stall_cycles", 64'(st), 64'(1));
    chk("lu_bubble", 64'(ov), 64'(0));
    idle(2);
    // lw $3 then add $4,$5,$5 -> no bubble
    s(32'h8C030000, mk(32'h8C030000, 7'b1011000, 5'd3, 3'b101, 3'b000));
    send(32'h00A52021, mk(32'h00A52021, 7'b0001000, 5'd4, 3'b101, 3'b000), 1'b1, st, ov);
    chk("nolu_stall_cycles", 64'(st), 64'(0));
    chk("nolu_no_bubble", 64'(ov), 64'(1));
    idle(2);

    // mult then mflo: one cycle while mult is consumed, then 4 busy cycles
    b_mult = mk(32'h00220019, 7'b0000000, 5'd0, 3'b100, 3'b000);
    b_mflo = mk(32'h00002812, 7'b0001000, 5'd5, 3'b010, 3'b000);
    s(32'h00220019, b_mult);
    send(32'h00002812, b_mflo, 1'b1, st, ov);
    chk("mul_stall_cycles", 64'(st), 64'(5));
    idle(8);
    // counter drained: mfhi issues immediately
    send(32'h00003010, mk(32'h00003010, 7'b0001000, 5'd6, 3'b011, 3'b000), 1'b1, st, ov);
    chk("mfhi_idle_stall", 64'(st), 64'(0));
    idle(2);

    // Backpressure: held bundle stays valid, fetch blocked
    dif.out_ready = 1'b0;
    send(32'h24020005, mk(32'h24020005, 7'b0011000, 5'd2, 3'b101, 3'b000), 1'b1, st, ov);
    idle(2);
    @(negedge clk);
    chk("hold_valid", 64'(dif.out_valid), 64'(1));
    chk("hold_in_ready", 64'(dif.in_ready), 64'(0));
    tick();
    dif.out_ready = 1'b1;
    idle(2);

    // Flush a held beq, and a held mult (which must not start the busy counter)
    flush_held(32'h10220004, mk(32'h10220004, 7'b0000010, 5'd2, 3'b001, 3'b000));
    flush_held(32'h00220019, b_mult);
    send(32'h00002812, b_mflo, 1'b1, st, ov);
    chk("flushed_mult_no_busy", 64'(st), 64'(0));
    idle(2);

    // Reset while the busy counter is running clears it
    s(32'h00220019, b_mult);
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(dif.in_ready), 64'(0));
    chk("midrst_out_valid", 64'(dif.out_valid), 64'(0));
    tick();
    reset = 1'b0;
    send(32'h00002812, b_mflo, 1'b1, st, ov);
    chk("post_rst_mflo_stall", 64'(st), 64'(0));
    idle(3);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_decode_stage.md
# mips_decode_stage

Registered, pipelined successor to the combinational MIPS instruction decoder. Sits between the fetch stage and the execute stage, decodes one instruction per cycle into a registered control bundle, and uses a valid/ready handshake on both sides. Adds the sequential behaviour the pipeline needs:
- load-use interlock that inserts one bubble;
- parametrised multiply-busy counter that stalls `mflo`/`mfhi` until the multiplier result is ready;
- flush on a taken branch;
- safe decoding of illegal instructions.

## Interface
- `MULT_LATENCY`, default 4: cycles after a `mult` issues before `mflo`/`mfhi` may issue; legal range 1 to 2^`CNT_W`-1.
- `CNT_W`, default 4: width of the multiply-busy counter.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: fetch presents `instr`.
- `in_ready` out 1: stage accepts `instr` this cycle.
- `instr` in 32: instruction word.
- `flush` in 1: taken branch or jump resolved in EX; kill the held instruction.
- `out_valid` out 1: control bundle valid.
- `out_ready` in 1: EX consumes the bundle.
- `instr_q` out 32: registered copy of the instruction.
- `memtoreg`, `memwrite`, `alusrcbimm`, `regwrite`, `dojump` out 1 each: same meaning as in the existing decoder.
- `isbranch` out 1: instruction is `beq` or `bne`.
- `branchne` out 1: branch condition is `!zero` (`bne`); EX resolves the branch.
- `destreg` out 5: target register.
- `alucontrol` out 3: add 101, sub 001, and 111, or 110, slt 000, mult 100, mflo 010, mfhi 011.
- `immhi` out 1: immediate goes to the upper half (`lui`).
- `immzext` out 1: immediate is zero-extended (`ori`).
- `illegal` out 1: opcode or funct is not decodable.

## Operation
- Decode table:
  - R-type (op 000000), funct: 100001 add, 100011 sub, 100100 and, 100101 or, 101011 slt, 011001 mult, 010000 mfhi, 010010 mflo.
  - I-type: `lw` 100011, `sw` 101011, `beq` 000100, `bne` 000101, `addiu` 001001.
  - Jump: `j` 000010.
  - Extended: `lui` 001111, `ori` 001101.
- `destreg`: `instr[15:11]` for R-type, `instr[20:16]` for I-type, 0 otherwise.
- `lw` sets `memtoreg`=1 and `regwrite`=1. `sw` sets `memwrite`=1 and `regwrite`=0.
- `mult` sets `regwrite`=0; the HI/LO registers are written internally by the multiplier.
- Illegal opcode or R-type funct:
  - `illegal`=1.
  - `regwrite`, `memwrite`, `isbranch`, `dojump` all 0.
  - `alucontrol`=101.
  - No X values are ever driven.
- Output register loads on `in_valid && in_ready`.
- Otherwise `out_valid` clears when `out_valid && out_ready`. It holds when `out_valid && !out_ready`.
- `in_ready = (!out_valid || out_ready) && !flush && !lu_stall && !mul_stall`.
- `lu_stall` (load-use): all of the following hold:
  - held bundle is `lw` with `destreg` ≠ 0;
  - held bundle is being consumed this cycle;
  - incoming instr reads that register: `rs` for any type, or `rt` for R-type, `beq`, `bne`, `sw`.
  
  Result: exactly one bubble cycle, with `out_valid`=0 in the next cycle.
- `mul_stall`: busy counter ≠ 0 and incoming instr is `mflo`, `mfhi` or `mult`.
- Busy counter:
  - loads `MULT_LATENCY` when a `mult` bundle is consumed (`out_valid && out_ready`);
  - otherwise decrements by 1 while nonzero;
  - saturates at 0.
- `flush`:
  - `out_valid`→0 next cycle, regardless of `out_ready`;
  - `in_ready`=0 in the flush cycle;
  - busy counter unaffected. A flushed `mult` was never consumed, so it never loads the counter.

## Timing
- Latency: 1 cycle from acceptance to `out_valid`. Throughput: 1 instruction per cycle when no stall occurs.
- Reset values:
  - `out_valid`=0, busy counter=0;
  - `instr_q`=0, `destreg`=0, `alucontrol`=101;
  - all other control outputs 0.
- Reset may assert mid-stall; all state clears immediately. `in_ready` is 0 while `reset` is high.
- `flush` has priority over acceptance, and over a simultaneous `out_ready`.
- `lu_stall` and `mul_stall` are evaluated combinationally in the same cycle as `in_valid`. The stalled instruction stays on `instr`, and fetch must hold it.
- Counter boundary: with `MULT_LATENCY`=N, `mflo` is accepted in the Nth cycle after the `mult` consumption edge, once the counter reads 0.

## Configuration
- `DECODE_EXT_EN` defined: `lui` and `ori` decode.
  - `lui`: `regwrite`=1, `alusrcbimm`=1, `alucontrol`=101, `immhi`=1.
  - `ori`: `regwrite`=1, `alusrcbimm`=1, `alucontrol`=110, `immzext`=1.
- `DECODE_EXT_EN` undefined: opcodes 001111 and 001101 decode as illegal; `immhi` and `immzext` are tied to 0.

## Test plan
- Reset, then `addiu $2,$0,5` (0x24020005) with `out_ready`=1 → next cycle `out_valid`=1, `regwrite`=1, `destreg`=2, `alusrcbimm`=1, `alucontrol`=101.
- `lw $3,0($0)`, then `add $4,$3,$3` back-to-back → one cycle with `out_valid`=0 between them. Same sequence with `add $4,$5,$5` → no bubble.
- `MULT_LATENCY`=4: `mult $1,$2`, then `mflo $5` → `in_ready`=0 for 4 cycles after the `mult` is consumed; then `alucontrol`=010, `destreg`=5.
- Hold `out_ready`=0 with `beq` held, then pulse `flush` → `out_valid`=0 next cycle, `in_ready`=0 during the flush cycle, and the `beq` bundle is never consumed.
- Opcode 0x3F and R-funct 0x3F → `illegal`=1, `regwrite`=0, `memwrite`=0, `alucontrol`=101.
- `lui $1,0x1234` → with `DECODE_EXT_EN`: `immhi`=1, `regwrite`=1, `destreg`=1. Without it: `illegal`=1, `regwrite`=0.
